// File: rtl/uart_sdram_bridge.sv
// UART byte-command bridge onto a single-word SDRAM request port.
// Frames: 'W'/'R', big-endian address, length-1, then write data.
module uart_sdram_bridge #(
    parameter int AddrWidth = 22,
    parameter int DataWidth = 16,
    parameter int WrGap     = 8,
    parameter int RdTimeout = 1024
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_rdy,
    output logic                 o_rx_req,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_req,
    input  logic                 i_tx_rdy,
    output logic                 o_wr_req,
    output logic [AddrWidth-1:0] o_wr_addr,
    output logic [DataWidth-1:0] o_wr_data,
    output logic                 o_rd_req,
    output logic [AddrWidth-1:0] o_rd_addr,
    input  logic [DataWidth-1:0] i_rd_data,
    input  logic                 i_rd_rdy,
    output logic                 o_busy
);
    localparam int AddrBytes = (AddrWidth + 7) / 8;
    localparam int DataBytes = (DataWidth + 7) / 8;
    localparam int RdW       = DataBytes * 8;
    localparam int TmrMax    = (RdTimeout > WrGap) ? RdTimeout : WrGap;
    localparam int TmrW      = $clog2(TmrMax + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, LEN, WDATA, WISSUE, WGAP,
        RISSUE, RWAIT, RSEND, ACK, NAK
    } state_t;

    state_t state, state_n;

    logic                 cmd_wr;
    logic                 rd_err;
    logic                 tx_hold;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [RdW-1:0]       rdata;
    logic [7:0]           byte_cnt;
    logic [7:0]           len_cnt;
    logic [TmrW-1:0]      timer;

    logic                 take;
    logic                 rx_open;
    logic                 tx_ok;
    logic                 tx_fire;
    logic [7:0]           tx_byte;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 word_next;
    logic [AddrWidth+7:0] addr_sh;
    logic [DataWidth+7:0] data_sh;

    // A byte is consumed on the edge that ends the o_rx_req pulse.
    assign take    = o_rx_req;
    assign tx_ok   = i_tx_rdy && !tx_hold;
    assign addr_sh = {addr, i_rx_data};
    assign data_sh = {wdata, i_rx_data};
    assign o_busy  = (state != IDLE);

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        rx_open   = 1'b0;
        tx_fire   = 1'b0;
        tx_byte   = 8'h00;
        wr_fire   = 1'b0;
        rd_fire   = 1'b0;
        word_next = 1'b0;
        unique case (state)
            IDLE: begin
                rx_open = 1'b1;
                if (take) begin
                    if (i_rx_data == 8'h57 || i_rx_data == 8'h52)
                        state_n = ADDR;
                    else
                        state_n = NAK;
                end
            end
            ADDR: begin
                rx_open = 1'b1;
                if (take && byte_cnt == 8'(AddrBytes - 1)) state_n = LEN;
            end
            LEN: begin
                rx_open = 1'b1;
                if (take) state_n = cmd_wr ? WDATA : RISSUE;
            end
            WDATA: begin
                rx_open = 1'b1;
                if (take && byte_cnt == 8'(DataBytes - 1)) state_n = WISSUE;
            end
            WISSUE: begin
                wr_fire = 1'b1;
                state_n = WGAP;
            end
            WGAP: begin
                if (timer == TmrW'(WrGap - 2)) begin
                    if (len_cnt == 8'd0) begin
                        state_n = ACK;
                    end else begin
                        state_n   = WDATA;
                        word_next = 1'b1;
                    end
                end
            end
            RISSUE: begin
                rd_fire = 1'b1;
                state_n = RWAIT;
            end
            RWAIT: begin
                if (i_rd_rdy)                          state_n = RSEND;
                else if (timer == TmrW'(RdTimeout - 1)) state_n = NAK;
            end
            RSEND: begin
                if (tx_ok) begin
                    tx_fire = 1'b1;
                    tx_byte = rdata[RdW-1 -: 8];
                    if (byte_cnt == 8'(DataBytes - 1)) begin
                        if (len_cnt == 8'd0) begin
                            state_n = IDLE;
                        end else begin
                            state_n   = RISSUE;
                            word_next = 1'b1;
                        end
                    end
                end
            end
            ACK: begin
                if (tx_ok) begin
                    tx_fire = 1'b1;
                    tx_byte = 8'h4B;
                    state_n = IDLE;
                end
            end
            NAK: begin
                if (tx_ok) begin
                    tx_fire = 1'b1;
                    tx_byte = rd_err ? 8'hEE : 8'h3F;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_req  <= 1'b0;
            o_tx_req  <= 1'b0;
            o_tx_data <= '0;
            o_wr_req  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_rd_req  <= 1'b0;
            o_rd_addr <= '0;
            cmd_wr    <= 1'b0;
            rd_err    <= 1'b0;
            tx_hold   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            byte_cnt  <= '0;
            len_cnt   <= '0;
            timer     <= '0;
        end else begin
            o_rx_req <= rx_open && i_rx_rdy && !o_rx_req;
            o_tx_req <= tx_fire;
            o_wr_req <= wr_fire;
            o_rd_req <= rd_fire;

            // Next byte waits until the transmitter has been seen busy.
            if (tx_fire) begin
                o_tx_data <= tx_byte;
                tx_hold   <= 1'b1;
            end else if (!i_tx_rdy) begin
                tx_hold <= 1'b0;
            end

            if (state_n != state)
                timer <= '0;
            else if (state == WGAP || state == RWAIT)
                timer <= timer + 1'b1;

            if (state_n != state)
                byte_cnt <= '0;
            else if (take || tx_fire)
                byte_cnt <= byte_cnt + 8'd1;

            if (take && state == IDLE) begin
                cmd_wr <= (i_rx_data == 8'h57);
                rd_err <= 1'b0;
            end
            if (take && state == ADDR)  addr    <= addr_sh[AddrWidth-1:0];
            if (take && state == LEN)   len_cnt <= i_rx_data;
            if (take && state == WDATA) wdata   <= data_sh[DataWidth-1:0];
            if (word_next)              len_cnt <= len_cnt - 8'd1;

            if (wr_fire) begin
                o_wr_addr <= addr;
                o_wr_data <= wdata;
                addr      <= addr + 1'b1;
            end
            if (rd_fire) begin
                o_rd_addr <= addr;
                addr      <= addr + 1'b1;
            end

            if (state == RWAIT && i_rd_rdy)
                rdata <= RdW'(i_rd_data);
            else if (tx_fire && state == RSEND)
                rdata <= rdata << 8;

            if (state == RWAIT && state_n == NAK) rd_err <= 1'b1;
        end
    end
endmodule

// File: doc/uart_sdram_bridge.md
UART_SDRAM_BRIDGE -- requirements
Module: uart_sdram_bridge

Interface
REQ-001 Parameters (name, default, meaning):
- AddrWidth, 22, SDRAM word address width.
- DataWidth, 16, SDRAM word width.
- WrGap, 8, minimum cycles between successive o_wr_req pulses; at least 2.
- RdTimeout, 1024, maximum cycles from o_rd_req to i_rd_rdy.
- Derived: AddrBytes = ceil(AddrWidth/8); DataBytes = ceil(DataWidth/8).
REQ-002 Ports (name, direction, width, meaning):
- i_sys_clk, in, 1, sole clock, rising edge.
- i_rst, in, 1, reset, asynchronous, active-high.
- i_rx_data, in, 8, received UART byte.
- i_rx_rdy, in, 1, received byte available.
- o_rx_req, out, 1, one-cycle pulse that consumes the received byte.
- o_tx_data, out, 8, byte to transmit.
- o_tx_req, out, 1, one-cycle transmit pulse.
- i_tx_rdy, in, 1, UART transmitter idle.
- o_wr_req, out, 1, SDRAM write request pulse.
- o_wr_addr, out, AddrWidth, write address.
- o_wr_data, out, DataWidth, write data.
- o_rd_req, out, 1, SDRAM read request pulse.
- o_rd_addr, out, AddrWidth, read address.
- i_rd_data, in, DataWidth, read data.
- i_rd_rdy, in, 1, read data valid.
- o_busy, out, 1, high whenever the FSM is not in IDLE.

Function
REQ-003 RX handshake: when i_rx_rdy=1 and o_rx_req=0, the block SHALL pulse o_rx_req for exactly 1 cycle and capture i_rx_data in that cycle; it SHALL capture no byte while o_rx_req=1.
REQ-004 TX handshake: the block SHALL pulse o_tx_req for 1 cycle only when i_tx_rdy=1, with o_tx_data held stable from the pulse until the next pulse. After each pulse it SHALL observe i_tx_rdy=0 at least once before issuing the next pulse.
REQ-005 Frame format: command byte, then AddrBytes address bytes (MSB first), then a length byte L; the transfer covers L+1 words (1..256).
- Command 0x57 ('W') is followed by (L+1)*DataBytes data bytes, MSB first per word.
- Command 0x52 ('R') is followed by no further bytes.
REQ-006 Address assembly: bits above AddrWidth SHALL be discarded. Data assembly: bits above DataWidth SHALL be discarded.
REQ-007 FSM states: IDLE, ADDR, LEN, WDATA, WISSUE, WGAP, RISSUE, RWAIT, RSEND, ACK, NAK.
REQ-008 In IDLE, command byte 0x57 or 0x52 -> ADDR. Any other byte -> NAK.
REQ-009 Transitions ADDR -> LEN after AddrBytes bytes; LEN -> WDATA (write) or RISSUE (read).
REQ-010 Write path: WDATA collects one word, then goes to WISSUE. WISSUE pulses o_wr_req for 1 cycle with o_wr_addr/o_wr_data valid in that cycle, then goes to WGAP. WGAP waits WrGap-1 cycles, then goes to WDATA if words remain, else ACK.
REQ-011 Read path: RISSUE pulses o_rd_req for 1 cycle with o_rd_addr valid, then goes to RWAIT. RWAIT latches i_rd_data on i_rd_rdy=1, then goes to RSEND. RSEND transmits DataBytes bytes MSB first (zero-padded above DataWidth), then goes to RISSUE if words remain, else IDLE.
REQ-012 Read timeout: if RdTimeout cycles elapse in RWAIT without i_rd_rdy, the block SHALL transmit 0xEE, abort the remaining words, and return to IDLE.
REQ-013 Address increment: the word address SHALL increment by 1 after each word, wrapping modulo 2^AddrWidth.
REQ-014 ACK transmits 0x4B ('K') then goes to IDLE. NAK transmits 0x3F ('?') then goes to IDLE.
REQ-015 i_rd_rdy pulses arriving outside RWAIT SHALL be ignored. Received bytes SHALL NOT be consumed (o_rx_req stays 0) in WISSUE, WGAP, RISSUE, RWAIT, RSEND, ACK or NAK.
REQ-016 o_wr_req and o_rd_req SHALL never be high in the same cycle. Each SHALL be high for at most 1 consecutive cycle.

Reset
REQ-017 While i_rst=1, asynchronously: FSM=IDLE; all counters and capture registers = 0; o_rx_req, o_tx_req, o_wr_req, o_rd_req, o_busy = 0; o_tx_data, o_wr_addr, o_wr_data, o_rd_addr = 0.
REQ-018 Reset asserted mid-frame SHALL abandon the frame. After release, the next byte SHALL be parsed as a command.

Verification
REQ-019 Defaults; RX 57 00 01 02 00 AB CD -> one o_wr_req with addr 0x000102, data 0xABCD; then TX 0x4B.
REQ-020 RX 52 3F FF FF 01 with rd model returning 0x1234 then 0x5678 -> o_rd_addr 0x3FFFFF then 0x000000 (wrap); TX 12 34 56 78.
REQ-021 RX 57 00 00 00 02 + 6 data bytes -> 3 o_wr_req pulses at addr 0,1,2, each spaced >= 8 cycles; TX 0x4B.
REQ-022 RX 0x41 -> TX 0x3F, no SDRAM request; a following valid frame is processed normally.
REQ-023 RX 52 00 00 10 00 with i_rd_rdy held 0 -> exactly 1024 cycles in RWAIT, then TX 0xEE, o_busy falls.
REQ-024 Assert i_rst mid-WDATA -> all outputs 0 immediately; after release, RX 52 00 00 00 00 performs a normal read.
